// File: rtl/ntt_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ntt_seq_pkg
// Description : Shared types and constants for the NTT phase sequencer, the
//               257-lane address generator and the butterfly datapath.
//               - seq_state_e    : sequencer state encoding
//               - MODE_ADD/SHIFT : address generator mode values
//               - c_DEPTH, c_NUM_PASSES, c_PIPE_LAT : default geometry
//               - clog2_min1     : width helper that never returns zero
// Revision    : 1.0 - initial release
// ============================================================================
package ntt_seq_pkg;

    localparam int unsigned c_DEPTH      = 85;
    localparam int unsigned c_NUM_PASSES = 3;
    localparam int unsigned c_PIPE_LAT   = 4;

    localparam logic MODE_ADD   = 1'b0;
    localparam logic MODE_SHIFT = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_SETUP_LOAD   = 4'd1,
        ST_LOAD         = 4'd2,
        ST_SETUP_COMP   = 4'd3,
        ST_COMPUTE      = 4'd4,
        ST_DRAIN        = 4'd5,
        ST_SETUP_UNLOAD = 4'd6,
        ST_UNLOAD       = 4'd7,
        ST_DONE         = 4'd8
    } seq_state_e;

    // Counter width for a range of v values; a single-value range still
    // needs one bit so that port and register declarations stay legal.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_delay.sv
`default_nettype none
// ============================================================================
// Module      : pipe_delay
// Description : PIPE_LAT-deep 1-bit shift register with synchronous clear.
//               Used to turn the read-issue strobe into the butterfly
//               writeback strobe.
//   clk     in  clock
//   i_clr   in  synchronous clear of the whole delay line
//   i_din   in  strobe input
//   o_dout  out i_din delayed by PIPE_LAT cycles
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_delay #(
    parameter int unsigned PIPE_LAT = 4
) (
    input  logic clk,
    input  logic i_clr,
    input  logic i_din,
    output logic o_dout
);

    generate
        if (PIPE_LAT == 0) begin : g_bypass
            assign o_dout = i_din;
        end else begin : g_shift
            logic [PIPE_LAT-1:0] r_sr;

            always_ff @(posedge clk) begin
                if (i_clr) begin
                    r_sr <= '0;
                end else begin
                    r_sr[0] <= i_din;
                    for (int i = 1; i < PIPE_LAT; i++) begin
                        r_sr[i] <= r_sr[i-1];
                    end
                end
            end

            assign o_dout = r_sr[PIPE_LAT-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/ntt_addr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ntt_addr_sequencer
// Description : Phase controller for the 257-lane modular address generator.
//               Steps LOAD -> NUM_PASSES x COMPUTE/DRAIN -> UNLOAD, driving
//               the generator's reset/mode/incr and the coefficient bank
//               strobes, with a start/done handshake to the NTT top level.
//   clk, reset           clock, synchronous active-high reset
//   start / busy / done  transform handshake (done is a one-cycle pulse)
//   in_valid / in_ready  load-side stream
//   out_valid / out_ready unload-side stream
//   ag_reset/ag_mode/ag_incr  address generator controls
//   mem_we / mem_re / wb_en   bank write, compute read issue, writeback
//   pass_idx / word_idx       current compute pass and word within phase
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_addr_sequencer
    import ntt_seq_pkg::*;
#(
    parameter  int unsigned DEPTH      = c_DEPTH,
    parameter  int unsigned NUM_PASSES = c_NUM_PASSES,
    parameter  int unsigned PIPE_LAT   = c_PIPE_LAT,
    localparam int unsigned c_WORD_W   = clog2_min1(DEPTH),
    localparam int unsigned c_PASS_W   = clog2_min1(NUM_PASSES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                ag_reset,
    output logic                ag_mode,
    output logic                ag_incr,
    output logic                mem_we,
    output logic                mem_re,
    output logic                wb_en,
    output logic [c_PASS_W-1:0] pass_idx,
    output logic [c_WORD_W-1:0] word_idx
);

    localparam int unsigned         c_DRN_W     = clog2_min1(PIPE_LAT);
    localparam logic [c_WORD_W-1:0] c_WORD_LAST = c_WORD_W'(DEPTH - 1);
    localparam logic [c_PASS_W-1:0] c_PASS_LAST = c_PASS_W'(NUM_PASSES - 1);
    localparam logic [c_DRN_W-1:0]  c_DRN_LAST  = c_DRN_W'(PIPE_LAT - 1);

    seq_state_e          r_state;
    seq_state_e          w_state_nxt;
    logic [c_WORD_W-1:0] r_word_idx;
    logic [c_PASS_W-1:0] r_pass_idx;
    logic [c_DRN_W-1:0]  r_drn_cnt;

    logic w_word_inc;
    logic w_word_clr;
    logic w_pass_inc;
    logic w_pass_clr;
    logic w_drn_inc;

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_word_idx <= '0;
            r_pass_idx <= '0;
            r_drn_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_word_clr) begin
                r_word_idx <= '0;
            end else if (w_word_inc) begin
                r_word_idx <= r_word_idx + 1'b1;
            end

            if (w_pass_clr) begin
                r_pass_idx <= '0;
            end else if (w_pass_inc) begin
                r_pass_idx <= r_pass_idx + 1'b1;
            end

            // Runs only while DRAIN is counting; any other cycle parks it at 0.
            r_drn_cnt <= w_drn_inc ? r_drn_cnt + 1'b1 : '0;
        end
    end

    // ------------------------------------------------------------------
    // Next state and Moore/Mealy outputs. Handshake-qualified strobes
    // (mem_we, ag_incr in LOAD/UNLOAD) are combinational with the
    // accepting cycle so the generator advances on the same edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        ag_reset    = 1'b0;
        ag_mode     = MODE_ADD;
        ag_incr     = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        w_word_inc  = 1'b0;
        w_word_clr  = 1'b0;
        w_pass_inc  = 1'b0;
        w_pass_clr  = 1'b0;
        w_drn_inc   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = ST_SETUP_LOAD;
                end
            end

            ST_SETUP_LOAD: begin
                ag_reset    = 1'b1;
                w_word_clr  = 1'b1;
                w_state_nxt = ST_LOAD;
            end

            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mem_we  = 1'b1;
                    ag_incr = 1'b1;
                    if (r_word_idx == c_WORD_LAST) begin
                        w_word_clr  = 1'b1;
                        w_pass_clr  = 1'b1;
                        w_state_nxt = ST_SETUP_COMP;
                    end else begin
                        w_word_inc = 1'b1;
                    end
                end
            end

            ST_SETUP_COMP: begin
                // Mode must already be SHIFT while ag_reset is high: the
                // generator's reset value is mode dependent.
                ag_reset    = 1'b1;
                ag_mode     = MODE_SHIFT;
                w_word_clr  = 1'b1;
                w_state_nxt = ST_COMPUTE;
            end

            ST_COMPUTE: begin
                ag_mode = MODE_SHIFT;
                mem_re  = 1'b1;
                ag_incr = 1'b1;
                if (r_word_idx == c_WORD_LAST) begin
                    w_word_clr  = 1'b1;
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_word_inc = 1'b1;
                end
            end

            ST_DRAIN: begin
                // Wait out the butterfly pipeline so the pass's last
                // writeback lands before the next pass re-reads the bank.
                ag_mode = MODE_SHIFT;
                if (r_drn_cnt == c_DRN_LAST) begin
                    if (r_pass_idx == c_PASS_LAST) begin
                        w_state_nxt = ST_SETUP_UNLOAD;
                    end else begin
                        w_pass_inc  = 1'b1;
                        w_state_nxt = ST_SETUP_COMP;
                    end
                end else begin
                    w_drn_inc = 1'b1;
                end
            end

            ST_SETUP_UNLOAD: begin
                ag_reset    = 1'b1;
                w_word_clr  = 1'b1;
                w_state_nxt = ST_UNLOAD;
            end

            ST_UNLOAD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    ag_incr = 1'b1;
                    if (r_word_idx == c_WORD_LAST) begin
                        w_word_clr  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_word_inc = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                done        = 1'b1;
                w_pass_clr  = 1'b1;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                busy        = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign pass_idx = r_pass_idx;
    assign word_idx = r_word_idx;

    // Writeback strobe: read issue delayed by the butterfly latency.
    pipe_delay #(
        .PIPE_LAT (PIPE_LAT)
    ) u_wb_dly (
        .clk    (clk),
        .i_clr  (reset),
        .i_din  (mem_re),
        .o_dout (wb_en)
    );

endmodule
`default_nettype wire

// File: tb/tb_ntt_addr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ntt_addr_sequencer
// Description : Self-checking bench for ntt_addr_sequencer. Each run builds
//               an expected per-cycle output trace from the phase rules
//               (load accepts, fixed compute/drain windows, unload
//               transfers), drives the matching stimulus and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ntt_addr_sequencer;

    localparam int DEPTH = 85;
    localparam int NPASS = 3;
    localparam int LAT   = 4;

    logic       clk = 1'b0;
    logic       reset, start, in_valid, out_ready;
    logic       busy, done, in_ready, out_valid;
    logic       ag_reset, ag_mode, ag_incr, mem_we, mem_re, wb_en;
    logic [1:0] pass_idx;
    logic [6:0] word_idx;

    always #5 clk = ~clk;

    ntt_addr_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ag_reset  (ag_reset),
        .ag_mode   (ag_mode),
        .ag_incr   (ag_incr),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .wb_en     (wb_en),
        .pass_idx  (pass_idx),
        .word_idx  (word_idx)
    );

    typedef struct packed {
        logic       busy, done, in_ready, out_valid, ag_reset, ag_mode;
        logic       ag_incr, mem_we, mem_re, wb_en;
        logic [1:0] pass_idx;
        logic [6:0] word_idx;
    } vec_t;

    vec_t dut_v;
    assign dut_v = {busy, done, in_ready, out_valid, ag_reset, ag_mode,
                    ag_incr, mem_we, mem_re, wb_en, pass_idx, word_idx};

    // Expected trace and per-cycle stimulus, indexed by run cycle k
    // (k = 0 is the IDLE cycle in which start is sampled).
    vec_t exp_q[$];
    bit   pchk_q[$];
    bit   iv_q[$];
    bit   or_q[$];
    bit   st_q[$];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int period;     // in_valid high once every 'period' LOAD cycles
        int stall_len;  // out_ready low cycles after 40 unload transfers
        int exp_lat;
        int exp_we;
        int exp_wb;
    } tbl_rec_t;

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input int k, input vec_t exp, input bit pchk);
        vec_t m;
        m = '1;
        if (!pchk) m.pass_idx = '0;
        checks++;
        if ((dut_v & m) !== (exp & m)) begin
            errors++;
            $display("FAIL %s k=%0d: got %b expected %b (busy,done,in_rdy,out_vld,ag_rst,mode,incr,we,re,wb,pass,word)",
                     name, k, dut_v, exp);
        end
    endtask

    task automatic add_exp(input vec_t v, input bit pc, input bit ivv, input bit orv);
        exp_q.push_back(v);
        pchk_q.push_back(pc);
        iv_q.push_back(ivv);
        or_q.push_back(orv);
        st_q.push_back(1'b0);
    endtask

    function automatic bit rbit();
        return $urandom_range(0, 1) != 0;
    endfunction

    task automatic build_model(input int period, input int stall_len, input bit rnd, input bit noise);
        vec_t v;
        int   w, n, stalled;
        bit   b;
        exp_q.delete(); pchk_q.delete(); iv_q.delete(); or_q.delete(); st_q.delete();

        v = '0;
        add_exp(v, 1'b0, rbit(), rbit());                  // IDLE, start sampled
        v = '0; v.busy = 1; v.ag_reset = 1;
        add_exp(v, 1'b0, rbit(), rbit());                  // load setup

        w = 0; n = 0;
        while (w < DEPTH) begin
            b = rnd ? ($urandom_range(0, 2) == 0) : ((n % period) == 0);
            n++;
            v = '0; v.busy = 1; v.in_ready = 1; v.word_idx = 7'(w);
            if (b) begin v.mem_we = 1; v.ag_incr = 1; w++; end
            add_exp(v, 1'b0, b, rbit());
        end

        for (int p = 0; p < NPASS; p++) begin
            v = '0; v.busy = 1; v.ag_reset = 1; v.ag_mode = 1; v.pass_idx = 2'(p);
            add_exp(v, 1'b1, rbit(), rbit());
            for (int i = 0; i < DEPTH; i++) begin
                v = '0; v.busy = 1; v.ag_mode = 1; v.mem_re = 1; v.ag_incr = 1;
                v.pass_idx = 2'(p); v.word_idx = 7'(i);
                add_exp(v, 1'b1, rbit(), rbit());
            end
            for (int i = 0; i < LAT; i++) begin
                v = '0; v.busy = 1; v.ag_mode = 1; v.pass_idx = 2'(p);
                add_exp(v, 1'b1, rbit(), rbit());
            end
        end

        v = '0; v.busy = 1; v.ag_reset = 1;
        add_exp(v, 1'b0, rbit(), rbit());                  // unload setup

        w = 0; stalled = 0;
        while (w < DEPTH) begin
            if (rnd) b = rbit();
            else     b = !(w == 40 && stalled < stall_len);
            if (!b) stalled++;
            v = '0; v.busy = 1; v.out_valid = 1; v.word_idx = 7'(w);
            if (b) begin v.ag_incr = 1; w++; end
            add_exp(v, 1'b0, rbit(), b);
        end

        v = '0; v.busy = 1; v.done = 1;
        add_exp(v, 1'b0, rbit(), rbit());                  // DONE
        v = '0;
        add_exp(v, 1'b0, rbit(), rbit());                  // back to IDLE

        // Writeback strobe is the read issue seen LAT cycles earlier.
        for (int k = 0; k < exp_q.size(); k++) begin
            v = exp_q[k];
            v.wb_en = (k >= LAT) ? exp_q[k-LAT].mem_re : 1'b0;
            exp_q[k] = v;
        end

        st_q[0] = 1'b1;
        if (noise) begin
            for (int k = 1; k < exp_q.size() - 1; k++) st_q[k] = ($urandom_range(0, 3) == 0);
            st_q[exp_q.size() - 2] = 1'b1;                 // start during DONE
        end
    endtask

    task automatic run(input int abort_at, output int done_k, output int n_we, output int n_wb);
        done_k = -1; n_we = 0; n_wb = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(posedge clk); #1;
            in_valid  = iv_q[k];
            out_ready = or_q[k];
            start     = st_q[k];
            if (k == abort_at) reset = 1'b1;
            @(negedge clk);
            chk_vec("trace", k, exp_q[k], pchk_q[k]);
            if (done && done_k < 0) done_k = k;
            if (mem_we) n_we++;
            if (wb_en)  n_wb++;
            if (k == abort_at) begin
                @(posedge clk); #1;
                reset = 1'b0; start = 1'b0;
                @(negedge clk);
                chk_vec("after_reset_all_zero", k + 1, '0, 1'b1);
                return;
            end
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            start = 1'b0; in_valid = rbit(); out_ready = rbit();
            @(negedge clk);
            chk_int("no_second_run", {30'd0, busy, done}, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl_rec_t tbl[4];
        int dk, nwe, nwb;

        tbl[0] = '{1,  0, 443, 85, 255};
        tbl[1] = '{3,  0, 611, 85, 255};
        tbl[2] = '{1, 10, 453, 85, 255};
        tbl[3] = '{2, 10, 537, 85, 255};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_vec("reset_state", 0, '0, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int t = 0; t < 4; t++) begin
            build_model(tbl[t].period, tbl[t].stall_len, 1'b0, 1'b0);
            run(-1, dk, nwe, nwb);
            chk_int($sformatf("tbl%0d_done_cycle", t), dk, tbl[t].exp_lat);
            chk_int($sformatf("tbl%0d_mem_we_count", t), nwe, tbl[t].exp_we);
            chk_int($sformatf("tbl%0d_wb_en_count", t), nwb, tbl[t].exp_wb);
        end

        // start asserted while busy and during DONE
        build_model(1, 0, 1'b0, 1'b1);
        run(-1, dk, nwe, nwb);
        chk_int("start_ignored_done_cycle", dk, 443);

        // reset during DRAIN of pass 1, then a clean rerun
        build_model(1, 0, 1'b0, 1'b0);
        run(264, dk, nwe, nwb);
        build_model(1, 0, 1'b0, 1'b0);
        run(-1, dk, nwe, nwb);
        chk_int("rerun_done_cycle", dk, 443);
        chk_int("rerun_wb_en_count", nwb, 255);

        // randomized throttling on both streams plus start noise
        for (int r = 0; r < 4; r++) begin
            build_model(1, 0, 1'b1, 1'b1);
            run(-1, dk, nwe, nwb);
            chk_int($sformatf("rnd%0d_done_cycle", r), dk, exp_q.size() - 2);
            chk_int($sformatf("rnd%0d_mem_we_count", r), nwe, DEPTH);
            chk_int($sformatf("rnd%0d_wb_en_count", r), nwb, NPASS * DEPTH);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ntt_addr_sequencer.md
Name: ntt_addr_sequencer

Overview:
- Phase controller for the 257-lane modular address generator.
- Drives the generator's reset, mode and incr controls through three phases: LOAD (in-order write of coefficients), COMPUTE (NUM_PASSES butterfly passes using the shifted/rotated addressing) and UNLOAD (in-order read-out).
- Provides a start/done handshake to the NTT top level, plus valid/ready streams on the load and unload sides.

Parameters:
DEPTH, 85, words per lane per phase (must match the address generator modulus)
NUM_PASSES, 3, number of COMPUTE passes
PIPE_LAT, 4, butterfly pipeline latency in cycles from mem_re to writeback

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
start  input  1  begin transform; sampled only in IDLE
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on completion
in_valid  input  1  load-side data valid
in_ready  output  1  load-side ready
out_valid  output  1  unload-side data valid
out_ready  input  1  unload-side ready
ag_reset  output  1  to address generator reset
ag_mode  output  1  to address generator mode (0 = add, 1 = shift)
ag_incr  output  1  to address generator incr
mem_we  output  1  coefficient bank write enable (load)
mem_re  output  1  coefficient bank read enable (compute issue)
wb_en  output  1  butterfly writeback enable, mem_re delayed PIPE_LAT cycles
pass_idx  output  $clog2(NUM_PASSES)  current compute pass (twiddle select)
word_idx  output  $clog2(DEPTH)  word counter within current phase

Behaviour:
Reset
- reset=1 forces state IDLE, clears all counters and the wb_en delay line, and drives all outputs to 0 on the next edge.
- Reset applies mid-operation with no drain; any in-flight wb_en is discarded.

States: IDLE, SETUP_LOAD, LOAD, SETUP_COMP, COMPUTE, DRAIN, SETUP_UNLOAD, UNLOAD, DONE.

SETUP_* states (one cycle each)
- ag_reset=1; ag_mode=0 for LOAD/UNLOAD setup, 1 for COMPUTE setup.
- ag_mode is valid in the same cycle as ag_reset, because the generator's reset value depends on mode.
- word_idx cleared.

IDLE
- start=1 -> SETUP_LOAD.
- start in any other state is ignored.

LOAD
- in_ready=1, ag_mode=0.
- On in_valid&in_ready: mem_we=1, ag_incr=1, word_idx++ (all combinational with the handshake).
- After the DEPTH-th accept -> SETUP_COMP with pass_idx=0.
- in_valid=0 stalls with no increment.

COMPUTE
- ag_mode=1; mem_re=1 and ag_incr=1 every cycle, no stalls.
- After DEPTH issues -> DRAIN.

DRAIN
- mem_re=0, ag_incr=0 for exactly PIPE_LAT cycles; wb_en keeps draining.
- Then, if pass_idx<NUM_PASSES-1: pass_idx++ and -> SETUP_COMP; else -> SETUP_UNLOAD.

UNLOAD
- out_valid=1, ag_mode=0.
- On out_valid&out_ready: ag_incr=1, word_idx++.
- After DEPTH transfers -> DONE.
- out_ready=0 holds out_valid and addresses.

DONE
- done=1 for one cycle, busy=1 -> IDLE.
- start asserted in DONE is ignored.

Timing and widths
- wb_en(t) = mem_re(t-PIPE_LAT) exactly; the last wb_en of each pass falls in the final DRAIN cycle.
- Stall-free latency: start sampled at cycle 0 -> done at cycle 2 + 2*(DEPTH+1) + NUM_PASSES*(DEPTH+1+PIPE_LAT) - 1, which is 443 at defaults.
- in_ready and out_valid are never both high.
- word_idx wraps to 0 at the end of each phase and never reaches DEPTH.

Decomposition:
- Package ntt_seq_pkg holds:
  - the state enum;
  - MODE_ADD=1'b0 and MODE_SHIFT=1'b1;
  - the default DEPTH/NUM_PASSES/PIPE_LAT constants, shared with the address generator and butterfly.
- One sub-module, pipe_delay: a PIPE_LAT-deep 1-bit shift register with synchronous clear, producing wb_en.

Test Plan:
- Reset then start at cycle 0, in_valid=1 and out_ready=1 throughout:
  - ag_reset high at cycles 1, 87, 177, 267, 357;
  - ag_mode=1 only from 87 through 356;
  - done pulses at cycle 443, busy low at 444.
- Throttle in_valid to 1 cycle in 3 during LOAD:
  - exactly 85 mem_we/ag_incr pulses;
  - word_idx ends at 84 then wraps;
  - no transition to SETUP_COMP before the 85th accept.
- Hold out_ready=0 for 10 cycles mid-UNLOAD:
  - out_valid stays 1, ag_incr=0, word_idx is frozen;
  - total UNLOAD transfers remain 85.
- Assert reset during DRAIN of pass 1:
  - next cycle all outputs 0, state IDLE, wb_en 0;
  - a subsequent start reproduces the scenario-1 timing exactly.
- Check wb_en across a full run:
  - wb_en equals mem_re delayed by 4 cycles;
  - exactly 255 wb_en pulses in total;
  - pass_idx takes 0, 1, 2 over the three pass windows.
- Assert start while busy and again during DONE: both are ignored and no second run occurs.
